// File: rtl/alu_issue.sv
// alu_issue: decode-and-issue stage in front of the 64-bit RV64I ALU.
// Decodes OP, OP-IMM and BRANCH instructions into ALU operands and controls.
// Results are held in a single registered output slot with valid/ready flow control.
// Optional feature macro: ALU_ISSUE_SCOREBOARD_EN enables the 32-entry busy
// scoreboard and the read-after-write stall. Without it, hazard is tied low.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [63:0] rf_rdata1,
  input  logic [63:0] rf_rdata2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] op0,
  output logic [63:0] op1,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [5:0]  ctrl,
  output logic [4:0]  out_rd,
  output logic [2:0]  br_cond,
  output logic        illegal,
  output logic [31:0] issue_count
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  logic [6:0]  opcode;
  logic        isOp, isImm, isBr, isIllegal;
  logic        hazard, accept, slotLoad;

  logic [63:0] op0_d, op1_d;
  logic [2:0]  func3_d, brCond_d;
  logic [6:0]  func7_d;
  logic [5:0]  ctrl_d;
  logic [4:0]  outRd_d;

  logic        outValid_q, illegal_q;
  logic [63:0] op0_q, op1_q;
  logic [2:0]  func3_q, brCond_q;
  logic [6:0]  func7_q;
  logic [5:0]  ctrl_q;
  logic [4:0]  outRd_q;
  logic [31:0] issueCount_q;

  assign opcode    = in_instr[6:0];
  assign isOp      = (opcode == OpcOp);
  assign isImm     = (opcode == OpcOpImm);
  assign isBr      = (opcode == OpcBranch);
  assign isIllegal = !(isOp || isImm || isBr);

  assign rf_raddr1 = in_instr[19:15];
  assign rf_raddr2 = in_instr[24:20];

  assign in_ready = (!outValid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign slotLoad = accept && !isIllegal;

  // Decode the presented instruction into the values the slot would capture.
  always_comb begin
    op0_d    = rf_rdata1;
    op1_d    = rf_rdata2;
    func3_d  = in_instr[14:12];
    func7_d  = in_instr[31:25];
    ctrl_d   = 6'b000000;
    outRd_d  = in_instr[11:7];
    brCond_d = 3'b000;
    if (isImm) begin
      op1_d   = {{52{in_instr[31]}}, in_instr[31:20]};
      func7_d = 7'b0000000;
      ctrl_d  = 6'b000001;
      if (in_instr[14:12] == 3'b101) begin
        func7_d = in_instr[31:25] & 7'b0111110;
        op1_d   = {58'b0, in_instr[25:20]};
      end else if (in_instr[14:12] == 3'b001) begin
        op1_d   = {58'b0, in_instr[25:20]};
      end
    end else if (isBr) begin
      func3_d  = 3'b000;
      func7_d  = 7'b0000000;
      brCond_d = in_instr[14:12];
      outRd_d  = 5'd0;
      ctrl_d   = 6'b000010;
    end
  end

`ifdef ALU_ISSUE_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        useRs2;

  assign useRs2 = isOp || isBr;
  assign hazard = !isIllegal &&
                  (((rf_raddr1 != 5'd0) && busy_q[rf_raddr1]) ||
                   (useRs2 && (rf_raddr2 != 5'd0) && busy_q[rf_raddr2]));

  // Next busy vector: writeback and flush clear, a fresh issue sets and wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (flush && outValid_q && (outRd_q != 5'd0)) busy_d[outRd_q] = 1'b0;
    if (slotLoad && (outRd_d != 5'd0)) busy_d[outRd_d] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; no bypass, so a clear is visible one cycle later.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
`else
  logic unusedWb;
  assign hazard   = 1'b0;
  assign unusedWb = ^{wb_valid, wb_rd};
`endif

  // Output slot, illegal pulse and issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q   <= 1'b0;
      illegal_q    <= 1'b0;
      op0_q        <= '0;
      op1_q        <= '0;
      func3_q      <= '0;
      func7_q      <= '0;
      ctrl_q       <= '0;
      outRd_q      <= '0;
      brCond_q     <= '0;
      issueCount_q <= '0;
    end else begin
      illegal_q <= accept && isIllegal;
      if (flush) begin
        outValid_q <= 1'b0;
      end else if (slotLoad) begin
        outValid_q   <= 1'b1;
        op0_q        <= op0_d;
        op1_q        <= op1_d;
        func3_q      <= func3_d;
        func7_q      <= func7_d;
        ctrl_q       <= ctrl_d;
        outRd_q      <= outRd_d;
        brCond_q     <= brCond_d;
        issueCount_q <= issueCount_q + 32'd1;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = outValid_q;
  assign op0         = op0_q;
  assign op1         = op1_q;
  assign func3       = func3_q;
  assign func7       = func7_q;
  assign ctrl        = ctrl_q;
  assign out_rd      = outRd_q;
  assign br_cond     = brCond_q;
  assign illegal     = illegal_q;
  assign issue_count = issueCount_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors with hand-computed expectations for alu_issue.
// Scoreboard-specific stalls are checked when ALU_ISSUE_SCOREBOARD_EN is defined.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wb_valid, flush, out_valid, out_ready, illegal;
  logic [31:0] in_instr, issue_count;
  logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, out_rd;
  logic [63:0] rf_rdata1, rf_rdata2, op0, op1;
  logic [2:0]  func3, br_cond;
  logic [6:0]  func7;
  logic [5:0]  ctrl;

  logic [63:0] regs [32];
  int compareCount  = 0;
  int mismatchCount = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Register file model; x0 always reads zero.
  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 64'd0 : regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 64'd0 : regs[rf_raddr2];

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op0(op0), .op1(op1), .func3(func3), .func7(func7), .ctrl(ctrl),
    .out_rd(out_rd), .br_cond(br_cond), .illegal(illegal), .issue_count(issue_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr);
    in_valid = valid;
    in_instr = instr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    regs[1] = 64'd5;
    regs[2] = 64'd7;
    regs[3] = 64'd100;
    regs[6] = 64'd42;
    regs[9] = 64'd11;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; wb_valid = 1'b0; wb_rd = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_op0", op0, 0);
    checkOutput("rst_ctrl", ctrl, 0);
    checkOutput("rst_issue_count", issue_count, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // ADD x3,x1,x2
    applyStimulus(1, 32'h002081B3);
    checkOutput("add_in_ready", in_ready, 1);
    checkOutput("add_raddr1", rf_raddr1, 1);
    checkOutput("add_raddr2", rf_raddr2, 2);
    tick();
    // ADDI x5,x1,-1 presented back-to-back
    applyStimulus(1, 32'hFFF08293);
    checkOutput("add_out_valid", out_valid, 1);
    checkOutput("add_op0", op0, 5);
    checkOutput("add_op1", op1, 7);
    checkOutput("add_func3", func3, 0);
    checkOutput("add_func7", func7, 0);
    checkOutput("add_out_rd", out_rd, 3);
    checkOutput("add_ctrl", ctrl, 0);
    checkOutput("add_issue_count", issue_count, 1);
    checkOutput("addi_in_ready", in_ready, 1);
    tick();
    // SLLI x5,x1,33
    applyStimulus(1, 32'h02109293);
    checkOutput("addi_op1", op1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_func7", func7, 0);
    checkOutput("addi_ctrl", ctrl, 6'b000001);
    checkOutput("addi_out_rd", out_rd, 5);
    checkOutput("addi_issue_count", issue_count, 2);
    tick();
    // SRAI x6,x1,37
    applyStimulus(1, 32'h4250D313);
    checkOutput("slli_op1", op1, 33);
    checkOutput("slli_func3", func3, 3'b001);
    checkOutput("slli_func7", func7, 0);
    tick();
    // BNE x1,x2 with rd/funct7 fields all ones
    applyStimulus(1, 32'hFE209FE3);
    checkOutput("srai_op1", op1, 37);
    checkOutput("srai_func3", func3, 3'b101);
    checkOutput("srai_func7", func7, 7'b0100000);
    checkOutput("srai_out_rd", out_rd, 6);
    tick();
    // Unsupported opcode
    applyStimulus(1, 32'h0000007F);
    checkOutput("br_op0", op0, 5);
    checkOutput("br_op1", op1, 7);
    checkOutput("br_func3", func3, 0);
    checkOutput("br_func7", func7, 0);
    checkOutput("br_cond", br_cond, 3'b001);
    checkOutput("br_out_rd", out_rd, 0);
    checkOutput("br_ctrl", ctrl, 6'b000010);
    checkOutput("illegal_in_ready", in_ready, 1);
    tick();
    applyStimulus(0, 32'h0);
    checkOutput("illegal_pulse", illegal, 1);
    checkOutput("illegal_out_valid", out_valid, 0);
    checkOutput("illegal_issue_count", issue_count, 5);
    tick();
    checkOutput("illegal_pulse_end", illegal, 0);

    // Backpressure: OR x7 held while XOR x8 waits
    out_ready = 1'b0;
    applyStimulus(1, 32'h0020E3B3);
    checkOutput("bp_empty_in_ready", in_ready, 1);
    tick();
    applyStimulus(1, 32'h0020C433);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_in_ready", in_ready, 0);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_rd", out_rd, 7);
      checkOutput("bp_hold_func3", func3, 3'b110);
      checkOutput("bp_hold_count", issue_count, 6);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", in_ready, 1);
    tick();
    applyStimulus(0, 32'h0);
    checkOutput("bp_next_valid", out_valid, 1);
    checkOutput("bp_next_rd", out_rd, 8);
    checkOutput("bp_next_func3", func3, 3'b100);
    checkOutput("bp_next_count", issue_count, 7);
    tick();
    checkOutput("drain_out_valid", out_valid, 0);

    // SUB x4,x3,x1 after ADD x3 (still busy unless scoreboard is disabled)
    applyStimulus(1, 32'h40118233);
`ifdef ALU_ISSUE_SCOREBOARD_EN
    checkOutput("raw_stall_empty_slot", in_ready, 0);
    tick();
    checkOutput("raw_stall_out_valid", out_valid, 0);
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    #1;
    checkOutput("raw_stall_clear_cycle", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("raw_released", in_ready, 1);
`else
    checkOutput("sub_in_ready", in_ready, 1);
`endif
    tick();
    applyStimulus(0, 32'h0);
    checkOutput("sub_func7", func7, 7'b0100000);
    checkOutput("sub_op0", op0, 100);
    checkOutput("sub_op1", op1, 5);
    checkOutput("sub_out_rd", out_rd, 4);
    checkOutput("sub_count", issue_count, 8);
    tick();

    // Flush a slot holding out_rd=6, then a reader of x6 must proceed
    out_ready = 1'b0;
    applyStimulus(1, 32'h00208333);
    checkOutput("fl_add6_in_ready", in_ready, 1);
    tick();
    applyStimulus(1, 32'h001304B3);
    checkOutput("fl_slot_rd", out_rd, 6);
    checkOutput("fl_slot_count", issue_count, 9);
    flush = 1'b1;
    #1;
    checkOutput("fl_in_ready_low", in_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("fl_out_valid", out_valid, 0);
    checkOutput("fl_busy6_cleared", in_ready, 1);
    tick();
    checkOutput("fl_next_rd", out_rd, 9);
    checkOutput("fl_next_op0", op0, 42);
    checkOutput("fl_next_count", issue_count, 10);

    // Reset while ADD x10,x9,x1 waits on x9
    out_ready = 1'b1;
    applyStimulus(1, 32'h00148533);
`ifdef ALU_ISSUE_SCOREBOARD_EN
    checkOutput("rs_stall", in_ready, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rs_out_valid", out_valid, 0);
    checkOutput("rs_op0", op0, 0);
    checkOutput("rs_op1", op1, 0);
    checkOutput("rs_func3", func3, 0);
    checkOutput("rs_func7", func7, 0);
    checkOutput("rs_ctrl", ctrl, 0);
    checkOutput("rs_out_rd", out_rd, 0);
    checkOutput("rs_br_cond", br_cond, 0);
    checkOutput("rs_illegal", illegal, 0);
    checkOutput("rs_count", issue_count, 0);
    applyStimulus(1, 32'h00148533);
    checkOutput("rs_busy_cleared", in_ready, 1);
    tick();
    applyStimulus(0, 32'h0);
    checkOutput("rs_reissue_rd", out_rd, 10);
    checkOutput("rs_reissue_op0", op0, 11);
    checkOutput("rs_reissue_count", issue_count, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
